// File: rtl/tdc_pulse_pair_gen_pkg.sv
// Shared definitions for the TDC stimulus generator: field widths, FSM states and sizing helper.
package tdc_pulse_pair_gen_pkg;

  localparam int unsigned TdcIntervalWidth = 12;
  localparam int unsigned TdcPassWidth     = 20;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2,
    StDead = 2'd3
  } gen_state_e;

  // Bits needed to hold max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tdc_pulse_shaper.sv
// Turns a one-cycle fire strobe into a registered active-low pulse PULSE_TICKS cycles wide.
module tdc_pulse_shaper
  import tdc_pulse_pair_gen_pkg::*;
#(
  parameter int unsigned PULSE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  output logic pulse_n,
  output logic last
);

  localparam int unsigned CntW = cnt_width(PULSE_TICKS - 1);

  logic [CntW-1:0] cnt_q;

  // A fire while already low restarts the width count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_n <= 1'b1;
      cnt_q   <= '0;
    end else if (fire) begin
      pulse_n <= 1'b0;
      cnt_q   <= CntW'(PULSE_TICKS - 1);
    end else if (!pulse_n) begin
      if (cnt_q == '0) begin
        pulse_n <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // High on the cycle whose closing edge releases the pulse.
  assign last = !pulse_n && (cnt_q == '0);

endmodule

// File: rtl/tdc_pulse_pair_gen.sv
// Emits start_n/stop_n falling-edge pairs a programmed interval apart, optionally as a burst
// separated by a dead time, to exercise the falling-edge TDC.
module tdc_pulse_pair_gen
  import tdc_pulse_pair_gen_pkg::*;
#(
  parameter int unsigned INTERVAL_WIDTH = TdcIntervalWidth,
  parameter int unsigned PASS_WIDTH     = TdcPassWidth,
  parameter int unsigned BURST_WIDTH    = 8,
  parameter int unsigned PULSE_TICKS    = 4,
  parameter int unsigned DEADTIME_TICKS = 2000000,
  parameter string       DEBUG          = "false"
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [INTERVAL_WIDTH-1:0] req_interval,
  input  logic [BURST_WIDTH-1:0]    req_count,
  output logic                      start_n,
  output logic                      stop_n,
  output logic                      busy,
  output logic                      done,
  output logic [PASS_WIDTH-1:0]     pair_count
);

  localparam int unsigned DeadW = cnt_width(DEADTIME_TICKS - 1);

  (* mark_debug = DEBUG *) gen_state_e state_q;

  logic                      launch_q;
  logic [INTERVAL_WIDTH-1:0] interval_q;
  logic [INTERVAL_WIDTH-1:0] ivl_cnt_q;
  logic [BURST_WIDTH-1:0]    remain_q;
  logic [DeadW-1:0]          dead_cnt_q;

  logic fire_start, fire_stop, start_last, stop_last, pulses_clear;

  // First RUN cycle launches start (and stop too for a zero interval); afterwards the
  // counter fires stop on the edge where it would reach zero.
  always_comb begin
    fire_start   = (state_q == StRun) && launch_q;
    fire_stop    = (state_q == StRun) &&
                   (launch_q ? (interval_q == '0) : (ivl_cnt_q == INTERVAL_WIDTH'(1)));
    pulses_clear = (start_n || start_last) && (stop_n || stop_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      launch_q   <= 1'b0;
      interval_q <= '0;
      ivl_cnt_q  <= '0;
      remain_q   <= '0;
      dead_cnt_q <= '0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pair_count <= '0;
    end else begin
      done <= 1'b0;
      if (fire_start) pair_count <= pair_count + 1'b1;
      unique case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            interval_q <= req_interval;
            remain_q   <= (req_count == '0) ? '0 : req_count - 1'b1;
            launch_q   <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          launch_q <= 1'b0;
          if (fire_stop) begin
            state_q <= StStop;
          end else if (launch_q) begin
            ivl_cnt_q <= interval_q;
          end else begin
            ivl_cnt_q <= ivl_cnt_q - 1'b1;
          end
        end
        StStop: begin
          if (pulses_clear) begin
            dead_cnt_q <= DeadW'(DEADTIME_TICKS - 1);
            state_q    <= StDead;
          end
        end
        StDead: begin
          if (dead_cnt_q != '0) begin
            dead_cnt_q <= dead_cnt_q - 1'b1;
          end else if (remain_q != '0) begin
            remain_q <= remain_q - 1'b1;
            launch_q <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q   <= StIdle;
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  tdc_pulse_shaper #(
    .PULSE_TICKS(PULSE_TICKS)
  ) u_start_shaper (
    .clk    (clk),
    .rst_n  (rst_n),
    .fire   (fire_start),
    .pulse_n(start_n),
    .last   (start_last)
  );

  tdc_pulse_shaper #(
    .PULSE_TICKS(PULSE_TICKS)
  ) u_stop_shaper (
    .clk    (clk),
    .rst_n  (rst_n),
    .fire   (fire_stop),
    .pulse_n(stop_n),
    .last   (stop_last)
  );

endmodule

// File: tb/tb_tdc_pulse_pair_gen.sv
// Randomized bench for tdc_pulse_pair_gen: each cycle's outputs are compared with a
// timeline computed from the pair schedule (start times, widths, period).
module tb_tdc_pulse_pair_gen;

  localparam int unsigned IW = 12;
  localparam int unsigned PW = 4;   // narrow pass counter so wrap happens quickly
  localparam int unsigned BW = 8;
  localparam int unsigned P  = 4;
  localparam int unsigned D  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_interval;
  logic [BW-1:0] req_count;
  logic          start_n, stop_n, busy, done;
  logic [PW-1:0] pair_count;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [PW-1:0] exp_pairs;

  always #5 clk = ~clk;

  tdc_pulse_pair_gen #(
    .INTERVAL_WIDTH(IW),
    .PASS_WIDTH    (PW),
    .BURST_WIDTH   (BW),
    .PULSE_TICKS   (P),
    .DEADTIME_TICKS(D),
    .DEBUG         ("false")
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_interval(req_interval),
    .req_count   (req_count),
    .start_n     (start_n),
    .stop_n      (stop_n),
    .busy        (busy),
    .done        (done),
    .pair_count  (pair_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {start_n, stop_n, busy, done, req_ready, pair_count}
  function automatic logic [31:0] observed();
    return 32'({start_n, stop_n, busy, done, req_ready, pair_count});
  endfunction

  function automatic logic [31:0] expect_vec(input logic s_n, input logic p_n, input logic b,
                                             input logic dn, input logic rdy,
                                             input logic [PW-1:0] pc);
    return 32'({s_n, p_n, b, dn, rdy, pc});
  endfunction

  task automatic idle_cycles(input int unsigned k);
    for (int unsigned j = 0; j < k; j++) begin
      @(posedge clk); #1;
      check_eq("idle", observed(), expect_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_pairs));
    end
  endtask

  // Issue one command and check every cycle until done. abort_at != 0 stops early at that
  // offset so the caller can apply reset mid-burst.
  task automatic run_cmd(input int unsigned ivl, input int unsigned cnt, input bit hold_valid,
                         input int unsigned abort_at);
    int unsigned   n;
    int unsigned   per;
    int unsigned   started;
    int unsigned   s;
    logic          s_lo, p_lo;
    logic [PW-1:0] base;
    n    = (cnt == 0) ? 1 : cnt;
    per  = ivl + P + D + 1;
    base = exp_pairs;
    req_valid    = 1'b1;
    req_interval = IW'(ivl);
    req_count    = BW'(cnt);
    for (int unsigned d = 0; d <= n * per; d++) begin
      @(posedge clk); #1;
      if (d == 0) begin
        req_valid    = hold_valid;
        req_interval = IW'($urandom);
        req_count    = BW'($urandom);
      end
      if (d == n * per) req_valid = 1'b0;
      started = 0;
      s_lo    = 1'b0;
      p_lo    = 1'b0;
      for (int unsigned k = 0; k < n; k++) begin
        s = 1 + k * per;
        if (d >= s) started++;
        if (d >= s && d < s + P) s_lo = 1'b1;
        if (d >= s + ivl && d < s + ivl + P) p_lo = 1'b1;
      end
      check_eq($sformatf("pair ivl=%0d cnt=%0d d=%0d", ivl, cnt, d), observed(),
               expect_vec(~s_lo, ~p_lo, d < n * per, d == n * per, d >= n * per,
                          base + PW'(started)));
      if (abort_at != 0 && d == abort_at) begin
        req_valid = 1'b0;
        exp_pairs = base + PW'(started);
        return;
      end
    end
    exp_pairs = base + PW'(n);
  endtask

  initial begin
    int unsigned ivl;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_interval = '0;
    req_count    = '0;
    exp_pairs    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset", observed(), expect_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_reset", observed(), expect_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0));

    run_cmd(100, 1, 1'b0, 0);
    idle_cycles(2);
    run_cmd(0, 1, 1'b0, 0);
    idle_cycles(1);
    run_cmd(2, 3, 1'b1, 0);
    run_cmd(4095, 1, 1'b0, 0);
    idle_cycles(1);
    run_cmd(1, 0, 1'b1, 0);

    for (int i = 0; i < 15; i++) begin
      ivl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 40);
      run_cmd(ivl, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
      idle_cycles($urandom_range(0, 3));
    end

    // Reset in the RUN phase of the second pair of a five-pair burst.
    run_cmd(10, 5, 1'b0, 1 + (10 + P + D + 1) + 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_pairs = '0;
    check_eq("abort_reset", observed(), expect_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ready", observed(), expect_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0));
    idle_cycles(20);
    run_cmd(7, 2, 1'b1, 0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
